// File: rtl/pixel_load_controller_pkg.sv
// Shared types and default geometry for the pixel frame loader.
// Imported by the address counter and the top-level controller.
package pixel_load_controller_pkg;

    localparam int PLC_IMG_W  = 64;
    localparam int PLC_IMG_H  = 48;
    localparam int PLC_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_BUSY = 2'd2
    } plc_state_e;

    // Pixel count of a frame, used to size and sanity-check address widths.
    function automatic int frame_pixels(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// Raster-order pixel index: column, row and linear address with clear and increment.
// Outputs reflect the index after any same-cycle clear, so a clear+increment writes pixel 0.
import pixel_load_controller_pkg::*;

module pixel_addr_counter #(
    parameter int IMG_W  = PLC_IMG_W,
    parameter int IMG_H  = PLC_IMG_H,
    parameter int ADDR_W = PLC_ADDR_W
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;

    logic [COL_W-1:0]  w_col_base;
    logic [ROW_W-1:0]  w_row_base;
    logic [ADDR_W-1:0] w_addr_base;
    logic              w_last;
    logic [COL_W-1:0]  w_col_nxt;
    logic [ROW_W-1:0]  w_row_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;

    // Effective index (after clear) and the index that follows it.
    always_comb begin
        w_col_base  = r_col;
        w_row_base  = r_row;
        w_addr_base = r_addr;
        if (i_clr) begin
            w_col_base  = {COL_W{1'b0}};
            w_row_base  = {ROW_W{1'b0}};
            w_addr_base = {ADDR_W{1'b0}};
        end else begin
            w_col_base  = r_col;
            w_row_base  = r_row;
            w_addr_base = r_addr;
        end

        w_last = (w_col_base == COL_MAX) && (w_row_base == ROW_MAX);

        w_col_nxt  = w_col_base;
        w_row_nxt  = w_row_base;
        w_addr_nxt = w_addr_base;
        if (i_inc) begin
            if (w_last) begin
                w_col_nxt  = {COL_W{1'b0}};
                w_row_nxt  = {ROW_W{1'b0}};
                w_addr_nxt = {ADDR_W{1'b0}};
            end else if (w_col_base == COL_MAX) begin
                w_col_nxt  = {COL_W{1'b0}};
                w_row_nxt  = w_row_base + ROW_W'(1);
                w_addr_nxt = w_addr_base + ADDR_W'(1);
            end else begin
                w_col_nxt  = w_col_base + COL_W'(1);
                w_row_nxt  = w_row_base;
                w_addr_nxt = w_addr_base + ADDR_W'(1);
            end
        end else begin
            w_col_nxt  = w_col_base;
            w_row_nxt  = w_row_base;
            w_addr_nxt = w_addr_base;
        end
    end

    // Index registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_col  <= {COL_W{1'b0}};
            r_row  <= {ROW_W{1'b0}};
            r_addr <= {ADDR_W{1'b0}};
        end else begin
            r_col  <= w_col_nxt;
            r_row  <= w_row_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    assign o_addr = w_addr_base;
    assign o_last = w_last;

endmodule

// File: rtl/pixel_load_controller.sv
// Loads a frame of SPI pixel bytes into the frame buffer, then hands the buffer
// to the edge core until it reports completion.
import pixel_load_controller_pkg::*;

module pixel_load_controller #(
    parameter int IMG_W  = PLC_IMG_W,
    parameter int IMG_H  = PLC_IMG_H,
    parameter int ADDR_W = PLC_ADDR_W
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              rxValid,
    input  logic [7:0]        rxData,
    input  logic              frameSync,
    input  logic              coreAck,
    input  logic              coreDone,
    input  logic [ADDR_W-1:0] coreAddr,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [7:0]        memWData,
    output logic              frameReady,
    output logic              coreGrant,
    output logic              overflow
);

    plc_state_e        r_state;
    plc_state_e        w_state_nxt;

    logic              w_in_load;
    logic              w_sync;
    logic              w_accept;
    logic              w_drop;
    logic [ADDR_W-1:0] w_cnt_addr;
    logic              w_cnt_last;

    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_mem_we;
    logic [7:0]        r_wdata;
    logic              r_frame_ready;
    logic              r_core_grant;
    logic              r_overflow;

    assign w_in_load = (r_state == ST_LOAD);
    assign w_sync    = frameSync & w_in_load;
    assign w_accept  = rxValid & w_in_load;
    assign w_drop    = rxValid & ~w_in_load;

    pixel_addr_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk    (clk),
        .nRst   (nRst),
        .i_clr  (w_sync),
        .i_inc  (w_accept),
        .o_addr (w_cnt_addr),
        .o_last (w_cnt_last)
    );

    // Next-state logic for the load / full / busy handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_accept && w_cnt_last) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (coreAck) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_BUSY: begin
                if (coreDone) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered frame-buffer write port and status flags, aligned with the state change.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wr_addr     <= {ADDR_W{1'b0}};
            r_mem_we      <= 1'b0;
            r_wdata       <= 8'h00;
            r_frame_ready <= 1'b0;
            r_core_grant  <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_mem_we      <= w_accept;
            r_frame_ready <= (w_state_nxt == ST_FULL);
            r_core_grant  <= (w_state_nxt == ST_BUSY);
            if (w_accept) begin
                r_wr_addr <= w_cnt_addr;
                r_wdata   <= rxData;
            end else begin
                r_wr_addr <= r_wr_addr;
                r_wdata   <= r_wdata;
            end
            if (w_sync) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // While granted, the core's read address passes straight through to the buffer.
    assign memAddr    = r_core_grant ? coreAddr : r_wr_addr;
    assign memWe      = r_mem_we;
    assign memWData   = r_wdata;
    assign frameReady = r_frame_ready;
    assign coreGrant  = r_core_grant;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_load_controller.sv
// Directed self-checking bench for pixel_load_controller on a 4x2 image.
module tb_pixel_load_controller;

    logic       clk;
    logic       nRst;
    logic       rxValid;
    logic [7:0] rxData;
    logic       frameSync;
    logic       coreAck;
    logic       coreDone;
    logic [2:0] coreAddr;
    logic [2:0] memAddr;
    logic       memWe;
    logic [7:0] memWData;
    logic       frameReady;
    logic       coreGrant;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    pixel_load_controller #(
        .IMG_W  (4),
        .IMG_H  (2),
        .ADDR_W (3)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .rxValid    (rxValid),
        .rxData     (rxData),
        .frameSync  (frameSync),
        .coreAck    (coreAck),
        .coreDone   (coreDone),
        .coreAddr   (coreAddr),
        .memAddr    (memAddr),
        .memWe      (memWe),
        .memWData   (memWData),
        .frameReady (frameReady),
        .coreGrant  (coreGrant),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0; rxValid = 1'b0; rxData = 8'h00; frameSync = 1'b0;
        coreAck = 1'b0; coreDone = 1'b0; coreAddr = 3'd0;
        tick(); tick();
        n_total++;
        if ({memAddr, memWe, memWData, frameReady, coreGrant, overflow} !== 15'd0)
            $display("FAIL reset_outputs: addr=%0d we=%0b data=%0h rdy=%0b gnt=%0b ovf=%0b expected all 0",
                     memAddr, memWe, memWData, frameReady, coreGrant, overflow);
        else n_pass++;
        #2 nRst = 1'b1;
        tick();
    endtask

    task automatic test_frame_load();
        for (int i = 0; i < 8; i++) begin
            rxValid = 1'b1; rxData = 8'h10 + 8'(i);
            tick();
            n_total++;
            if (memWe !== 1'b1 || memAddr !== 3'(i) || memWData !== 8'h10 + 8'(i))
                $display("FAIL load_write_%0d: we=%0b addr=%0d data=%0h expected 1/%0d/%0h",
                         i, memWe, memAddr, memWData, i, 8'h10 + 8'(i));
            else n_pass++;
            if (i == 6) begin
                n_total++;
                if (frameReady !== 1'b0) $display("FAIL ready_early: frameReady=%0b expected 0", frameReady);
                else n_pass++;
            end
        end
        rxValid = 1'b0;
        tick();
        n_total++;
        if (memWe !== 1'b0 || frameReady !== 1'b1)
            $display("FAIL frame_full: we=%0b ready=%0b expected 0/1", memWe, frameReady);
        else n_pass++;
    endtask

    task automatic test_core_handoff();
        coreAddr = 3'd5; coreAck = 1'b1;
        tick();
        coreAck = 1'b0;
        n_total++;
        if (coreGrant !== 1'b1 || memAddr !== 3'd5 || memWe !== 1'b0 || frameReady !== 1'b0)
            $display("FAIL grant: gnt=%0b addr=%0d we=%0b rdy=%0b expected 1/5/0/0",
                     coreGrant, memAddr, memWe, frameReady);
        else n_pass++;
        coreAddr = 3'd3;
        #1;
        n_total++;
        if (memAddr !== 3'd3) $display("FAIL grant_passthru: memAddr=%0d expected 3", memAddr);
        else n_pass++;
    endtask

    task automatic test_overflow();
        rxValid = 1'b1; rxData = 8'hAA;
        tick();
        rxValid = 1'b0;
        n_total++;
        if (memWe !== 1'b0 || overflow !== 1'b1)
            $display("FAIL busy_drop: we=%0b ovf=%0b expected 0/1", memWe, overflow);
        else n_pass++;
        coreDone = 1'b1;
        tick();
        coreDone = 1'b0;
        n_total++;
        if (coreGrant !== 1'b0 || memAddr !== 3'd7 || overflow !== 1'b1)
            $display("FAIL done: gnt=%0b addr=%0d ovf=%0b expected 0/7/1", coreGrant, memAddr, overflow);
        else n_pass++;
        coreAck = 1'b1;
        tick();
        coreAck = 1'b0;
        n_total++;
        if (coreGrant !== 1'b0 || frameReady !== 1'b0)
            $display("FAIL ack_in_load: gnt=%0b rdy=%0b expected 0/0", coreGrant, frameReady);
        else n_pass++;
        frameSync = 1'b1;
        tick();
        frameSync = 1'b0;
        n_total++;
        if (overflow !== 1'b0) $display("FAIL sync_clear: overflow=%0b expected 0", overflow);
        else n_pass++;
    endtask

    task automatic test_sync_collision();
        for (int i = 0; i < 3; i++) begin
            rxValid = 1'b1; rxData = 8'h30 + 8'(i);
            tick();
        end
        n_total++;
        if (memAddr !== 3'd2 || memWData !== 8'h32)
            $display("FAIL pre_sync: addr=%0d data=%0h expected 2/32", memAddr, memWData);
        else n_pass++;
        frameSync = 1'b1; rxData = 8'h55;
        tick();
        frameSync = 1'b0;
        n_total++;
        if (memWe !== 1'b1 || memAddr !== 3'd0 || memWData !== 8'h55)
            $display("FAIL sync_write: we=%0b addr=%0d data=%0h expected 1/0/55", memWe, memAddr, memWData);
        else n_pass++;
        rxData = 8'h66;
        tick();
        rxValid = 1'b0;
        n_total++;
        if (memWe !== 1'b1 || memAddr !== 3'd1 || memWData !== 8'h66)
            $display("FAIL post_sync: we=%0b addr=%0d data=%0h expected 1/1/66", memWe, memAddr, memWData);
        else n_pass++;
        tick();
        n_total++;
        if (memWe !== 1'b0) $display("FAIL we_single: memWe=%0b expected 0", memWe);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            rxValid = 1'b1; rxData = 8'h40 + 8'(i);
            tick();
        end
        rxValid = 1'b0;
        n_total++;
        if (memWe !== 1'b1 || memAddr !== 3'd6)
            $display("FAIL pre_reset: we=%0b addr=%0d expected 1/6", memWe, memAddr);
        else n_pass++;
        #2 nRst = 1'b0;
        #1;
        n_total++;
        if ({memAddr, memWe, memWData, frameReady, coreGrant, overflow} !== 15'd0)
            $display("FAIL async_reset: addr=%0d we=%0b data=%0h rdy=%0b gnt=%0b ovf=%0b expected all 0",
                     memAddr, memWe, memWData, frameReady, coreGrant, overflow);
        else n_pass++;
        #2 nRst = 1'b1;
        rxValid = 1'b1; rxData = 8'h77;
        tick();
        rxValid = 1'b0;
        n_total++;
        if (memWe !== 1'b1 || memAddr !== 3'd0 || memWData !== 8'h77)
            $display("FAIL post_reset: we=%0b addr=%0d data=%0h expected 1/0/77", memWe, memAddr, memWData);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame_load();
        test_core_handoff();
        test_overflow();
        test_sync_collision();
        test_async_reset();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
